pulse_to_level: RTL and testbench

Converts a single-cycle trigger pulse into a held output level lasting a programmable number of timebase ticks. It performs the inverse of the existing level-to-pulse conditioning. It sits between keypad/sensor event logic and long-lived outputs such as the unlock relay, alarm LED and buzzer enable. The timebase is an external tick strobe, normally from the binary pulse generator or the clock divider.

---
 rtl/security_pkg.sv | 23 ++
 rtl/tick_down_counter.sv | 50 +++++
 rtl/pulse_to_level.sv | 149 ++++++++++++++
 tb/tb_pulse_to_level.sv | 154 +++++++++++++++
 4 files changed

// File: rtl/security_pkg.sv
// Shared definitions for the security-panel output conditioning blocks.
//
// Contents:
//   HoldState          - state encoding of the pulse-to-level hold FSM
//   UNLOCK_HOLD_TICKS  - default unlock-relay window, in timebase ticks
//   ALARM_HOLD_TICKS   - default alarm LED / buzzer hold, in timebase ticks
//   max_int()          - elaboration-time maximum, used to size shared counters
package security_pkg;

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        ACTIVE  = 2'd1,
        HOLDOFF = 2'd2
    } HoldState;

    localparam int UNLOCK_HOLD_TICKS = 5;
    localparam int ALARM_HOLD_TICKS  = 30;

    function automatic int max_int(input int a, input int b);
        return (a > b) ? a : b;
    endfunction

endpackage

// File: rtl/tick_down_counter.sv
// Loadable down-counter advanced by an external tick strobe.
//
// Ports:
//   clk           in   system clock, posedge
//   reset         in   synchronous active-low reset (count -> 0)
//   load_i        in   load load_val_i this cycle (has priority over tick_en_i)
//   load_val_i    in   value to load
//   tick_en_i     in   decrement by one this cycle (saturates at zero)
//   count_next_o  out  value the counter takes on the next edge
//   zero_o        out  current count is zero
//   one_o         out  current count is one (the expiring tick is pending)
module tick_down_counter #(
    parameter int WIDTH = 3
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             load_i,
    input  logic [WIDTH-1:0] load_val_i,
    input  logic             tick_en_i,
    output logic [WIDTH-1:0] count_next_o,
    output logic             zero_o,
    output logic             one_o
);

    logic [WIDTH-1:0] count_q;
    logic [WIDTH-1:0] count_d;

    always_comb begin
        count_d = count_q;
        if (load_i) begin
            count_d = load_val_i;
        end else if (tick_en_i && (count_q != '0)) begin
            // Never decrement below zero, so the count can never wrap.
            count_d = count_q - 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            count_q <= '0;
        end else begin
            count_q <= count_d;
        end
    end

    assign count_next_o = count_d;
    assign zero_o       = (count_q == '0);
    assign one_o        = (count_q == WIDTH'(1));

endmodule

// File: rtl/pulse_to_level.sv
// Stretches a single-cycle trigger into a level held for HOLD_TICKS timebase
// ticks, with an optional holdoff window after natural expiry during which
// new triggers are ignored.
//
// Parameters:
//   HOLD_TICKS     ticks the level is held after a trigger (>= 1)
//   HOLDOFF_TICKS  ticks after natural expiry that ignore triggers (0 = none)
//   RETRIGGER      1 = trigger while held reloads the count, 0 = ignored
//
// Ports:
//   clk        in   system clock, posedge
//   reset      in   synchronous active-low reset
//   trigger    in   start request (a held level re-triggers every cycle)
//   tick       in   timebase strobe
//   cancel     in   immediate abort of the hold / holdoff, no done
//   level      out  registered held level
//   done       out  registered one-cycle pulse on natural expiry only
//   remaining  out  registered ticks left in the hold, 0 when not held
module pulse_to_level
    import security_pkg::*;
#(
    parameter int HOLD_TICKS    = 5,
    parameter int HOLDOFF_TICKS = 2,
    parameter int RETRIGGER     = 1
) (
    input  logic                            clk,
    input  logic                            reset,
    input  logic                            trigger,
    input  logic                            tick,
    input  logic                            cancel,
    output logic                            level,
    output logic                            done,
    output logic [$clog2(HOLD_TICKS+1)-1:0] remaining
);

    // One counter serves both the hold and the holdoff phase.
    localparam int CNT_MAX = max_int(HOLD_TICKS, HOLDOFF_TICKS);
    localparam int CW      = $clog2(CNT_MAX + 1);
    localparam int RW      = $clog2(HOLD_TICKS + 1);

    localparam logic [CW-1:0] HOLD_VAL    = CW'(HOLD_TICKS);
    localparam logic [CW-1:0] HOLDOFF_VAL = CW'(HOLDOFF_TICKS);

    HoldState state_q;
    HoldState state_d;

    logic          level_q;
    logic          done_q;
    logic          done_d;
    logic [RW-1:0] remaining_q;

    logic          cnt_load;
    logic [CW-1:0] cnt_load_val;
    logic          cnt_dec;
    logic [CW-1:0] cnt_next;
    logic          cnt_zero;
    logic          cnt_one;

    tick_down_counter #(
        .WIDTH (CW)
    ) u_counter (
        .clk          (clk),
        .reset        (reset),
        .load_i       (cnt_load),
        .load_val_i   (cnt_load_val),
        .tick_en_i    (cnt_dec),
        .count_next_o (cnt_next),
        .zero_o       (cnt_zero),
        .one_o        (cnt_one)
    );

    always_comb begin
        state_d      = state_q;
        cnt_load     = 1'b0;
        cnt_load_val = '0;
        cnt_dec      = 1'b0;
        done_d       = 1'b0;

        case (state_q)
            IDLE: begin
                // Cancel has nothing to abort here; a same-cycle tick is
                // not applied because the load takes priority.
                if (trigger) begin
                    state_d      = ACTIVE;
                    cnt_load     = 1'b1;
                    cnt_load_val = HOLD_VAL;
                end
            end

            ACTIVE: begin
                if (cancel) begin
                    state_d  = IDLE;
                    cnt_load = 1'b1;
                end else if (trigger && (RETRIGGER != 0)) begin
                    // Reload wins over a same-cycle tick, even the expiring one.
                    cnt_load     = 1'b1;
                    cnt_load_val = HOLD_VAL;
                end else if (tick && cnt_one) begin
                    done_d   = 1'b1;
                    cnt_load = 1'b1;
                    if (HOLDOFF_TICKS > 0) begin
                        state_d      = HOLDOFF;
                        cnt_load_val = HOLDOFF_VAL;
                    end else begin
                        state_d = IDLE;
                    end
                end else if (tick) begin
                    cnt_dec = 1'b1;
                end
            end

            HOLDOFF: begin
                // A zero count here would otherwise never leave HOLDOFF.
                if (cancel || (tick && (cnt_one || cnt_zero))) begin
                    state_d  = IDLE;
                    cnt_load = 1'b1;
                end else if (tick) begin
                    cnt_dec = 1'b1;
                end
            end

            default: begin
                state_d  = IDLE;
                cnt_load = 1'b1;
            end
        endcase
    end

    // Outputs are registered from next-state values so they line up with
    // the state register.
    always_ff @(posedge clk) begin
        if (!reset) begin
            state_q     <= IDLE;
            level_q     <= 1'b0;
            done_q      <= 1'b0;
            remaining_q <= '0;
        end else begin
            state_q     <= state_d;
            level_q     <= (state_d == ACTIVE);
            done_q      <= done_d;
            remaining_q <= (state_d == ACTIVE) ? RW'(cnt_next) : '0;
        end
    end

    assign level     = level_q;
    assign done      = done_q;
    assign remaining = remaining_q;

endmodule

// File: tb/tb_pulse_to_level.sv
module tb_pulse_to_level;

    logic       clk;
    logic       reset;
    logic       trigger;
    logic       tick;
    logic       cancel;

    logic       level_r1, done_r1;
    logic [1:0] remaining_r1;
    logic       level_r0, done_r0;
    logic [1:0] remaining_r0;

    int checks;
    int errors;

    pulse_to_level #(
        .HOLD_TICKS    (3),
        .HOLDOFF_TICKS (2),
        .RETRIGGER     (1)
    ) dut_r1 (
        .clk       (clk),
        .reset     (reset),
        .trigger   (trigger),
        .tick      (tick),
        .cancel    (cancel),
        .level     (level_r1),
        .done      (done_r1),
        .remaining (remaining_r1)
    );

    pulse_to_level #(
        .HOLD_TICKS    (3),
        .HOLDOFF_TICKS (2),
        .RETRIGGER     (0)
    ) dut_r0 (
        .clk       (clk),
        .reset     (reset),
        .trigger   (trigger),
        .tick      (tick),
        .cancel    (cancel),
        .level     (level_r0),
        .done      (done_r0),
        .remaining (remaining_r0)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic       rst_n;
        logic       trg;
        logic       tck;
        logic       cnl;
        logic       lvl;
        logic       dn;
        logic [1:0] rem;
    } vec_t;

    localparam int NVEC = 30;
    vec_t vecs [NVEC];

    task automatic step(input logic r, input logic t, input logic k, input logic c);
        reset   = r;
        trigger = t;
        tick    = k;
        cancel  = c;
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s: got %0d, expected %0d", name, act, exp);
        end
    endtask

    int exp_rem1, exp_rem0;

    initial begin
        checks  = 0;
        errors  = 0;
        reset   = 1'b0;
        trigger = 1'b0;
        tick    = 1'b0;
        cancel  = 1'b0;

        // rst_n trg tck cnl | level done remaining (after the edge)
        vecs[0]  = '{1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 2'd0}; // reset, trigger high
        vecs[1]  = '{1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 2'd0};
        vecs[2]  = '{1'b1, 1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 2'd3}; // release: armed
        vecs[3]  = '{1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 2'd3};
        vecs[4]  = '{1'b1, 1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 2'd2};
        vecs[5]  = '{1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 2'd2};
        vecs[6]  = '{1'b1, 1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 2'd1};
        vecs[7]  = '{1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 1'b1, 2'd0}; // expiry, done
        vecs[8]  = '{1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 2'd0}; // done drops
        vecs[9]  = '{1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 2'd0}; // holdoff ignores
        vecs[10] = '{1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 2'd0};
        vecs[11] = '{1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 2'd0}; // 1 tick after expiry
        vecs[12] = '{1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 2'd0}; // holdoff ends
        vecs[13] = '{1'b1, 1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 2'd3}; // accepted
        vecs[14] = '{1'b1, 1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 2'd2};
        vecs[15] = '{1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 2'd0}; // cancel at 2
        vecs[16] = '{1'b1, 1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 2'd3}; // no holdoff
        vecs[17] = '{1'b1, 1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 2'd2};
        vecs[18] = '{1'b1, 1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 2'd1};
        vecs[19] = '{1'b1, 1'b1, 1'b1, 1'b0, 1'b1, 1'b0, 2'd3}; // trg+tick at 1
        vecs[20] = '{1'b1, 1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 2'd2};
        vecs[21] = '{1'b1, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 2'd0}; // ACTIVE: cancel wins
        vecs[22] = '{1'b1, 1'b1, 1'b0, 1'b1, 1'b1, 1'b0, 2'd3}; // IDLE: trigger wins
        vecs[23] = '{1'b1, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 2'd0};
        vecs[24] = '{1'b1, 1'b1, 1'b1, 1'b0, 1'b1, 1'b0, 2'd3}; // IDLE trg+tick
        vecs[25] = '{1'b1, 1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 2'd2};
        vecs[26] = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 2'd0}; // reset mid-hold
        vecs[27] = '{1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 2'd0}; // IDLE ignores tick
        vecs[28] = '{1'b0, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 2'd0}; // reset dominates
        vecs[29] = '{1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 2'd0};

        for (int i = 0; i < NVEC; i++) begin
            step(vecs[i].rst_n, vecs[i].trg, vecs[i].tck, vecs[i].cnl);
            chk($sformatf("vec%0d level", i), int'(level_r1), int'(vecs[i].lvl));
            chk($sformatf("vec%0d done", i), int'(done_r1), int'(vecs[i].dn));
            chk($sformatf("vec%0d remaining", i), int'(remaining_r1), int'(vecs[i].rem));
        end

        // Periodic tick (every 4th cycle), trigger at c0, retrigger at c8,
        // one cycle after the second tick. RETRIGGER=1 holds through to c19;
        // RETRIGGER=0 ignores the retrigger and expires at c11.
        for (int c = 0; c < 28; c++) begin
            step(1'b1, (c == 0) || (c == 8), (c % 4) == 3, 1'b0);
            exp_rem1 = (c < 3) ? 3 : (c < 7) ? 2 : (c < 8) ? 1 :
                       (c < 11) ? 3 : (c < 15) ? 2 : (c < 19) ? 1 : 0;
            exp_rem0 = (c < 3) ? 3 : (c < 7) ? 2 : (c < 11) ? 1 : 0;
            chk($sformatf("retrig1 c%0d level", c), int'(level_r1), int'(c < 19));
            chk($sformatf("retrig1 c%0d done", c), int'(done_r1), int'(c == 19));
            chk($sformatf("retrig1 c%0d remaining", c), int'(remaining_r1), exp_rem1);
            chk($sformatf("retrig0 c%0d level", c), int'(level_r0), int'(c < 11));
            chk($sformatf("retrig0 c%0d done", c), int'(done_r0), int'(c == 11));
            chk($sformatf("retrig0 c%0d remaining", c), int'(remaining_r0), exp_rem0);
        end

        // Both instances back in IDLE: a fresh trigger arms them.
        step(1'b1, 1'b1, 1'b0, 1'b0);
        chk("rearm r1 remaining", int'(remaining_r1), 3);
        chk("rearm r0 remaining", int'(remaining_r0), 3);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
